// File: rtl/robertson_seq_cu_pkg.sv
// -----------------------------------------------------------------------------
// robertson_pkg
// Shared definitions for the Robertson multiplier control unit:
//   - rcu_state_t : FSM state encoding
//   - C_*         : bit positions of the micro-operation control word
//   - CW          : control-word width
// Optional feature macro used elsewhere in this slice: ROBERTSON_CU_ABORT_EN
// -----------------------------------------------------------------------------
package robertson_pkg;

  localparam int CW = 8;

  localparam int C_LD_AQ = 0;  // clear A and F, load Q
  localparam int C_LD_M  = 1;  // load M
  localparam int C_ADD   = 2;  // A <= A + M
  localparam int C_SUB   = 3;  // A <= A - M
  localparam int C_SHR   = 4;  // arithmetic shift right of F.A.Q
  localparam int C_CNT   = 5;  // iteration-count pulse
  localparam int C_OUT_A = 6;  // drive A to the output bus
  localparam int C_OUT_Q = 7;  // drive Q to the output bus

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_AQ = 3'd1,
    S_LD_M  = 3'd2,
    S_TEST  = 3'd3,
    S_SHIFT = 3'd4,
    S_OUT_A = 3'd5,
    S_OUT_Q = 3'd6,
    S_DONE  = 3'd7
  } rcu_state_t;

endpackage

// File: rtl/robertson_seq_cu_if.sv
// -----------------------------------------------------------------------------
// robertson_seq_cu_if
// Handshake and control bundle between the control unit and its environment.
//   start : request a multiplication (to CU)
//   q0    : current LSB of Q from the datapath (to CU)
//   abort : cancel the running operation (to CU, only with ROBERTSON_CU_ABORT_EN)
//   c     : control word, one bit per datapath micro-operation (from CU)
//   busy  : operation in progress (from CU)
//   stop  : one-cycle completion pulse (from CU)
// Modports: master = requester/datapath side, slave = control unit.
// -----------------------------------------------------------------------------
interface robertson_seq_cu_if;
  import robertson_pkg::*;

  logic          start;
  logic          q0;
  logic [CW-1:0] c;
  logic          busy;
  logic          stop;

`ifdef ROBERTSON_CU_ABORT_EN
  logic          abort;

  modport master (output start, output q0, output abort,
                  input  c, input busy, input stop);
  modport slave  (input  start, input q0, input abort,
                  output c, output busy, output stop);
`else
  modport master (output start, output q0,
                  input  c, input busy, input stop);
  modport slave  (input  start, input q0,
                  output c, output busy, output stop);
`endif

endinterface

// File: rtl/robertson_seq_cu_bit_counter.sv
// -----------------------------------------------------------------------------
// robertson_bit_counter
// Iteration counter for the Robertson control unit.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clr   : clear the count to zero
//   inc   : advance the count (saturates at N-1)
//   last  : high while the count equals N-1 (final iteration)
// -----------------------------------------------------------------------------
module robertson_bit_counter #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int           W      = (N <= 2) ? 1 : $clog2(N);
  localparam logic [W-1:0] LAST_V = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment; hold once the final iteration is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !last) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LAST_V);

endmodule

// File: rtl/robertson_seq_cu.sv
// -----------------------------------------------------------------------------
// robertson_seq_cu
// Control unit for a Robertson shift-and-add multiplier of width N.
// Parameters:
//   N      : operand width (>= 2)
//   SIGNED : 1 = final step subtracts (two's complement), 0 = final step adds
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : robertson_seq_cu_if.slave (start, q0, [abort], c, busy, stop)
// Optional feature: define ROBERTSON_CU_ABORT_EN to add the abort input,
// which returns any non-idle operation to IDLE without a stop pulse.
// -----------------------------------------------------------------------------
module robertson_seq_cu
  import robertson_pkg::*;
#(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  robertson_seq_cu_if.slave    bus
);

  rcu_state_t    state_q;
  rcu_state_t    state_d;
  rcu_state_t    fsm_next_s;
  logic [CW-1:0] c_s;
  logic          busy_s;
  logic          stop_s;
  logic          cnt_clr_s;
  logic          cnt_inc_s;
  logic          last_s;
  logic          abort_hit_s;

  robertson_bit_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .last  (last_s)
  );

`ifdef ROBERTSON_CU_ABORT_EN
  assign abort_hit_s = bus.abort && (state_q != S_IDLE);
`else
  assign abort_hit_s = 1'b0;
`endif

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; only q0 in TEST reaches the outputs combinationally
  always_comb begin
    fsm_next_s = state_q;
    c_s        = {CW{1'b0}};
    busy_s     = 1'b0;
    stop_s     = 1'b0;
    cnt_clr_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          fsm_next_s = S_LD_AQ;
        end else begin
          fsm_next_s = S_IDLE;
        end
      end
      S_LD_AQ: begin
        c_s[C_LD_AQ] = 1'b1;
        busy_s       = 1'b1;
        cnt_clr_s    = 1'b1;
        fsm_next_s   = S_LD_M;
      end
      S_LD_M: begin
        c_s[C_LD_M] = 1'b1;
        busy_s      = 1'b1;
        fsm_next_s  = S_TEST;
      end
      S_TEST: begin
        busy_s     = 1'b1;
        fsm_next_s = S_SHIFT;
        // The last partial product carries the sign weight in signed mode
        if (bus.q0 && last_s && SIGNED) begin
          c_s[C_SUB] = 1'b1;
        end else if (bus.q0) begin
          c_s[C_ADD] = 1'b1;
        end else begin
          c_s = {CW{1'b0}};
        end
      end
      S_SHIFT: begin
        c_s[C_SHR] = 1'b1;
        c_s[C_CNT] = 1'b1;
        busy_s     = 1'b1;
        cnt_inc_s  = 1'b1;
        if (last_s) begin
          fsm_next_s = S_OUT_A;
        end else begin
          fsm_next_s = S_TEST;
        end
      end
      S_OUT_A: begin
        c_s[C_OUT_A] = 1'b1;
        busy_s       = 1'b1;
        fsm_next_s   = S_OUT_Q;
      end
      S_OUT_Q: begin
        c_s[C_OUT_Q] = 1'b1;
        busy_s       = 1'b1;
        fsm_next_s   = S_DONE;
      end
      S_DONE: begin
        stop_s     = 1'b1;
        fsm_next_s = S_IDLE;
      end
      default: begin
        fsm_next_s = S_IDLE;
      end
    endcase
    state_d = abort_hit_s ? S_IDLE : fsm_next_s;
  end

  assign bus.c    = c_s;
  assign bus.busy = busy_s;
  assign bus.stop = stop_s;

endmodule

// File: tb/tb_robertson_seq_cu.sv
// -----------------------------------------------------------------------------
// tb_robertson_seq_cu
// Self-checking bench for robertson_seq_cu. Three instances run side by side:
// N=8 signed, N=8 unsigned, N=2 signed. Expected outputs come from a phase
// model: phase k counts cycles since start was accepted, and the outputs are
// derived from the documented cycle timing (LD_AQ at 1, LD_M at 2, TEST/SHIFT
// from 3 to 2N+2, OUT_A/OUT_Q at 2N+3/2N+4, stop at 2N+5).
// -----------------------------------------------------------------------------
module tb_robertson_seq_cu;

  logic clk;
  logic rst_n;
  logic start_v;
  logic q0_v;
  logic abort_v;

  int checks = 0;
  int errors = 0;

  int nn [3] = '{8, 8, 2};
  bit sg [3] = '{1'b1, 1'b0, 1'b1};
  int ph [3] = '{0, 0, 0};

  robertson_seq_cu_if b0 ();
  robertson_seq_cu_if b1 ();
  robertson_seq_cu_if b2 ();

  assign b0.start = start_v;
  assign b1.start = start_v;
  assign b2.start = start_v;
  assign b0.q0    = q0_v;
  assign b1.q0    = q0_v;
  assign b2.q0    = q0_v;
`ifdef ROBERTSON_CU_ABORT_EN
  assign b0.abort = abort_v;
  assign b1.abort = abort_v;
  assign b2.abort = abort_v;
`endif

  robertson_seq_cu #(.N(8), .SIGNED(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  robertson_seq_cu #(.N(8), .SIGNED(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  robertson_seq_cu #(.N(2), .SIGNED(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       q0;
    logic [7:0] c;
    logic       busy;
    logic       stop;
  } vec_t;

  vec_t tbl [22];

  // Expected {stop, busy, c} for a given phase
  function automatic logic [9:0] expv(int p, int n, bit s, logic q);
    logic [7:0] c;
    logic       b;
    logic       st;
    c  = 8'h00;
    b  = (p >= 1) && (p <= 2*n + 4);
    st = (p == 2*n + 5);
    if (p == 1) c = 8'h01;
    else if (p == 2) c = 8'h02;
    else if (p >= 3 && p <= 2*n + 2) begin
      if (((p - 3) % 2) == 0) begin
        if (q) c = (s && (p == 2*n + 1)) ? 8'h08 : 8'h04;
      end else begin
        c = 8'h30;
      end
    end
    else if (p == 2*n + 3) c = 8'h40;
    else if (p == 2*n + 4) c = 8'h80;
    return {st, b, c};
  endfunction

  function automatic int next_phase(int p, int n, logic r, logic s, logic ab);
    if (!r) return 0;
    if (ab && p != 0) return 0;
    if (p == 0) return s ? 1 : 0;
    if (p == 2*n + 5) return 0;
    return p + 1;
  endfunction

  function automatic logic [9:0] get_act(int i);
    case (i)
      0:       return {b0.stop, b0.busy, b0.c};
      1:       return {b1.stop, b1.busy, b1.c};
      default: return {b2.stop, b2.busy, b2.c};
    endcase
  endfunction

  task automatic cmp(string name, logic [9:0] act, logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cmpi(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 3; i++)
      cmp($sformatf("%s_dut%0d_ph%0d", tag, i, ph[i]), get_act(i), expv(ph[i], nn[i], sg[i], q0_v));
  endtask

  // Apply inputs for this cycle and let combinational outputs settle
  task automatic drive(logic s, logic q, logic r);
    start_v = s;
    q0_v    = q;
    rst_n   = r;
    #1;
  endtask

  // Advance one clock and step the model with the inputs seen at that edge
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      ph[i] = next_phase(ph[i], nn[i], rst_n, start_v, abort_v);
    #1;
  endtask

  task automatic reset_all();
    abort_v = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [9:0] a;
    int add_cnt, sub_cnt, shr, addsub, first;
    int stops[$];

    abort_v = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) cmp($sformatf("reset_dut%0d", i), get_act(i), 10'h000);
    drive(1'b0, 1'b0, 1'b1);

    // Directed table: N=8 signed, q0 held 1, start pulsed once
    for (int r = 0; r < 22; r++) begin
      tbl[r].start = (r == 0);
      tbl[r].q0    = 1'b1;
      tbl[r].busy  = (r >= 1 && r <= 20);
      tbl[r].stop  = (r == 21);
      if (r == 1) tbl[r].c = 8'h01;
      else if (r == 2) tbl[r].c = 8'h02;
      else if (r >= 3 && r <= 17 && (r % 2) == 1) tbl[r].c = (r == 17) ? 8'h08 : 8'h04;
      else if (r >= 4 && r <= 18) tbl[r].c = 8'h30;
      else if (r == 19) tbl[r].c = 8'h40;
      else if (r == 20) tbl[r].c = 8'h80;
      else tbl[r].c = 8'h00;
    end
    add_cnt = 0;
    sub_cnt = 0;
    for (int r = 0; r < 22; r++) begin
      drive(tbl[r].start, tbl[r].q0, 1'b1);
      cmp($sformatf("tbl_row%0d", r), get_act(0), {tbl[r].stop, tbl[r].busy, tbl[r].c});
      a = get_act(1);
      add_cnt += int'(a[2]);
      sub_cnt += int'(a[3]);
      check_all("tbl");
      tick();
    end
    cmpi("unsigned_add_count", add_cnt, 8);
    cmpi("unsigned_sub_count", sub_cnt, 0);

    // q0 held 0: no add/sub, eight shifts, stop at 21
    shr = 0; addsub = 0; first = -1;
    for (int k = 0; k < 23; k++) begin
      drive(k == 0, 1'b0, 1'b1);
      a = get_act(0);
      shr    += int'(a[4]);
      addsub += int'(a[2] | a[3]);
      if (a[9] && first < 0) first = k;
      check_all("q0zero");
      tick();
    end
    cmpi("q0zero_shift_count", shr, 8);
    cmpi("q0zero_addsub_count", addsub, 0);
    cmpi("q0zero_stop_cycle", first, 21);

    // Reset mid-operation with start held high
    reset_all();
    first = -1;
    for (int k = 0; k < 35; k++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), k != 10);
      a = get_act(0);
      if (k == 11) cmp("midrst_idle", a, 10'h000);
      if (k > 11 && a[9] && first < 0) first = k;
      check_all("midrst");
      tick();
    end
    cmpi("midrst_restart_stop", first, 32);

    // N=2 with start held: stop every 10 cycles, LD_AQ again at 11
    reset_all();
    stops = {};
    for (int k = 0; k < 41; k++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      a = get_act(2);
      if (a[9]) stops.push_back(k);
      if (k == 11) cmp("n2_ldaq_c11", a, {1'b0, 1'b1, 8'h01});
      check_all("n2");
      tick();
    end
    cmpi("n2_stop_count", stops.size(), 4);
    for (int j = 0; j < stops.size() && j < 4; j++)
      cmpi($sformatf("n2_stop%0d", j), stops[j], 9 + 10*j);

`ifdef ROBERTSON_CU_ABORT_EN
    reset_all();
    first = 0;
    for (int k = 0; k < 26; k++) begin
      abort_v = (k == 6);
      drive(k == 0, 1'($urandom_range(0, 1)), 1'b1);
      a = get_act(0);
      if (k == 7) cmp("abort_idle", a, 10'h000);
      first += int'(a[9]);
      check_all("abort");
      tick();
    end
    cmpi("abort_no_stop", first, 0);
    abort_v = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    tick();
    abort_v = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    cmp("abort_with_start", get_act(0), {1'b0, 1'b1, 8'h01});
    tick();
`endif

    // Randomized run against the phase model
    reset_all();
    for (int k = 0; k < 800; k++) begin
`ifdef ROBERTSON_CU_ABORT_EN
      abort_v = ($urandom_range(0, 24) == 0);
`endif
      drive($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 59) != 0);
      check_all("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/robertson_seq_cu.md
# robertson_seq_cu

Parametrised control unit for the Robertson (shift-and-add, two's-complement) multiplier. It generalises the fixed 8-bit sequence counter to any operand width N and adds a selectable unsigned mode. It has an internal iteration counter, an explicit start/stop handshake and an optional abort. It sits beside the A/Q/M/F datapath, samples the multiplier LSB `q0` and drives one control bit per datapath micro-operation.

## Interface
- `N`, 8: operand width in bits; must be at least 2.
- `SIGNED`, 1: 1 selects Robertson signed mode (last-step subtract); 0 selects unsigned mode (last-step add).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset: one clock; reset is synchronous and active-low.
- `start`  in  1  request a multiplication; sampled only in IDLE.
- `q0`  in  1  current LSB of Q from the datapath.
- `abort`  in  1  cancel the operation in progress (present only with the macro).
- `c`  out  8  control word, one bit per micro-operation.
- `busy`  out  1  operation in progress.
- `stop`  out  1  one-cycle completion pulse.

## Operation
- Control bits:
  - c[0]: clear A and F, load Q.
  - c[1]: load M.
  - c[2]: A <= A + M.
  - c[3]: A <= A − M.
  - c[4]: arithmetic shift right of F.A.Q.
  - c[5]: iteration-count pulse.
  - c[6]: drive A to the output bus.
  - c[7]: drive Q to the output bus.
- Internal counter `cnt`, width max(1,$clog2(N)).
  - Cleared in LD_AQ.
  - Incremented in SHIFT when `cnt` is not equal to N−1.
  - `last` = (`cnt` == N−1).
- FSM states and transitions:
  - IDLE: if `start`, go to LD_AQ; otherwise stay.
  - LD_AQ: c[0]; go to LD_M.
  - LD_M: c[1]; go to TEST.
  - TEST: go to SHIFT. The add/sub bit depends on `q0` (Mealy):
    - If `q0` and not `last`: c[2].
    - If `q0` and `last`: c[3] when SIGNED=1, c[2] when SIGNED=0.
    - If `q0`=0: neither c[2] nor c[3].
  - SHIFT: c[4] and c[5]; if `last`, go to OUT_A, else go to TEST.
  - OUT_A: c[6]; go to OUT_Q.
  - OUT_Q: c[7]; go to DONE.
  - DONE: `stop`=1; go to IDLE.
- Signal rules:
  - c[2] and c[3] are never asserted together.
  - No bit of `c` is asserted in IDLE or DONE.
  - `busy` is high in LD_AQ through OUT_Q inclusive.
- Boundary conditions:
  - `start` outside IDLE is ignored.
  - `start` held high continuously produces back-to-back operations separated by exactly one IDLE cycle.
  - `q0` is don't-care outside TEST.
  - `rst_n` low at any edge, including mid-operation: next state is IDLE and `cnt`=0; no `stop` pulse is produced.
  - Reset values: `c`=8'h00, `busy`=0, `stop`=0.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- LD_AQ occupies cycle 1 and LD_M occupies cycle 2.
- TEST/SHIFT pairs occupy cycles 3 … 2N+2.
- OUT_A is at cycle 2N+3, OUT_Q at 2N+4, DONE (`stop`) at 2N+5.
- Total latency is 2N+5 cycles; for N=8, `stop` is high in cycle 21.
- `c` is decoded from the registered state. The only combinational input path is `q0` into c[2]/c[3] in TEST, and it must settle within one cycle.
- `stop` and `busy` are decoded directly from the state, with no combinational input path.

## Configuration
- Macro `ROBERTSON_CU_ABORT_EN`.
- Defined:
  - The `abort` port exists.
  - `abort`=1 in any non-IDLE state sends the FSM to IDLE at the next edge, with `c`=0 and `busy`=0 in the next cycle and no `stop` pulse.
  - `abort` in IDLE is ignored; `start` still takes effect.
  - `rst_n` has priority over `abort`.
- Undefined: no `abort` port; the sequence always runs to DONE.

## Structure
- Package `robertson_pkg`:
  - State enum `rcu_state_t`.
  - Control-bit index localparams `C_LD_AQ`=0, `C_LD_M`=1, `C_ADD`=2, `C_SUB`=3, `C_SHR`=4, `C_CNT`=5, `C_OUT_A`=6, `C_OUT_Q`=7.
  - Control-word width localparam `CW`=8.
- Sub-module `robertson_bit_counter`:
  - Parametrised by N.
  - Inputs `clr` and `inc`; output `last`.
  - Same synchronous active-low reset as the parent.
- Top level holds only the FSM and output decode.

## Test plan
- N=8, SIGNED=1, `q0` held 1, `start` pulsed in cycle 0 -> c[2] in TEST cycles 3,5,…,15; c[3] only in cycle 17; c[6]/c[7] in cycles 19/20; `stop` in cycle 21.
- N=8, `q0` held 0 -> c[2] and c[3] never asserted; c[4] asserted exactly 8 times; `stop` in cycle 21.
- N=8, SIGNED=0, `q0` held 1 -> c[2] asserted in all 8 TEST cycles; c[3] never asserted.
- `start` held high; `rst_n` driven low in cycle 10 -> cycle 11 is IDLE with `c`=0, `busy`=0 and no `stop`; after release, the next operation yields `stop` at start+21.
- N=2 with `start` held high continuously -> `stop` at cycle 9; next LD_AQ at cycle 11; `stop` repeats every 10 cycles.
- With `ROBERTSON_CU_ABORT_EN`, N=8: `abort` pulsed in cycle 6 -> cycle 7 is IDLE, `busy`=0, no `stop`; `abort` asserted together with `start` in IDLE -> LD_AQ entered normally.
